// File: rtl/nv_ram_rwsp_param_if.sv
// Bus bundle for nv_ram_rwsp_param: read-address/enable, output-register enable,
// registered read data with valid tag, and the write port.
interface nv_ram_rwsp_param_if #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 11
) ();
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ra;
  logic             re;
  logic             ore;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    wa;
  logic             we;
  logic [WIDTH-1:0] di;

  modport master (
    output ra, re, ore, wa, we, di,
    input  dout, dout_vld
  );

  modport slave (
    input  ra, re, ore, wa, we, di,
    output dout, dout_vld
  );
endinterface

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R1W single-clock RAM: two-stage registered read, post-reset zero sweep,
// selectable read-during-write bypass. Define NV_RAM_PARITY_EN for per-word even parity.
module nv_ram_rwsp_param #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 11,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  nv_ram_rwsp_param_if.slave  bus,
  input  logic [31:0]         pwrbus_ram_pd,
  output logic                init_busy,
  output logic                parity_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef NV_RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    init_addr_reg, init_addr_next;
  logic [AW-1:0]    ra_d_reg, ra_d_next;
  logic             rd_pend_reg, rd_pend_next;
  logic [WIDTH-1:0] dout_reg;
  logic             dout_vld_reg;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    di_word;
  logic             ld_en;
  logic             wa_in_range;
  logic             rd_in_range;
  logic             bypass_hit;

  logic [MW-1:0]    mem_reg [DEPTH];

  // Power-down bus carries no function here; folded away so it is not flagged as dangling.
  logic unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;

  assign wa_in_range = ({1'b0, bus.wa} < DEPTH_L);
  assign rd_in_range = ({1'b0, ra_d_reg} < DEPTH_L);

`ifdef NV_RAM_PARITY_EN
  assign di_word = {^bus.di, bus.di};
`else
  assign di_word = bus.di;
`endif

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bypass_hit = bus.we && wa_in_range && (bus.wa == ra_d_reg);
    end else begin : g_no_bypass
      assign bypass_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      init_addr_reg <= '0;
      ra_d_reg      <= '0;
      rd_pend_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_addr_reg <= init_addr_next;
      ra_d_reg      <= ra_d_next;
      rd_pend_reg   <= rd_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_addr_next = init_addr_reg;
    ra_d_next      = ra_d_reg;
    rd_pend_next   = rd_pend_reg;
    wr_en          = 1'b0;
    wr_addr        = bus.wa;
    wr_word        = di_word;
    ld_en          = 1'b0;
    case (state_reg)
      INIT: begin
        wr_en          = 1'b1;
        wr_addr        = init_addr_reg;
        wr_word        = '0;
        init_addr_next = init_addr_reg + AW'(1);
        if (init_addr_reg == LAST_ADDR) begin
          state_next     = RUN;
          init_addr_next = '0;
        end
      end
      RUN: begin
        wr_en = bus.we && wa_in_range;
        ld_en = bus.ore;
        if (bus.re) begin
          ra_d_next    = bus.ra;
          rd_pend_next = 1'b1;
        end else if (bus.ore) begin
          rd_pend_next = 1'b0;
        end
      end
      default: state_next = INIT;
    endcase
    // The reset cycle itself must not disturb the array; the sweep starts on the next edge.
    if (rst) begin
      wr_en = 1'b0;
    end
  end

  assign init_busy = (state_reg == INIT);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_word;
    end
  end

  // Output register doubles as the RAM read register; a same-cycle write is still visible
  // here as old data unless the bypass path claims it.
`ifdef NV_RAM_PARITY_EN
  logic parity_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_vld_reg   <= 1'b0;
`ifdef NV_RAM_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else if (ld_en) begin
      dout_vld_reg <= rd_pend_reg;
      if (bypass_hit) begin
        dout_reg <= bus.di;
      end else if (rd_in_range) begin
        dout_reg <= mem_reg[ra_d_reg][WIDTH-1:0];
      end else begin
        dout_reg <= '0;
      end
`ifdef NV_RAM_PARITY_EN
      parity_err_reg <= rd_pend_reg && !bypass_hit && rd_in_range && (^mem_reg[ra_d_reg]);
`endif
    end
  end

  assign bus.dout     = dout_reg;
  assign bus.dout_vld = dout_vld_reg;

`ifdef NV_RAM_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/nv_ram_rwsp_param.md
Name: nv_ram_rwsp_param

Overview:
- Parametrised successor to the fixed-size 1R1W single-clock RAM wrappers (128x11 class).
- Generalised in depth and width, with a selectable read-during-write bypass mode.
- Adds a post-reset zero-initialisation sweep, a read-valid tag on the output, and optional per-word parity.
- Drop-in for datapath buffers that need a two-cycle registered read with a clean post-reset state.

Parameters:
- DEPTH, 128, number of words; must be >= 2. AW = clog2(DEPTH) is a derived localparam.
- WIDTH, 11, data bits per word; must be >= 1.
- BYPASS, 1, collision mode. 1 = a read collides with a same-cycle write and returns the new data (di). 0 = it returns the old array contents.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ra  input  AW  read address.
- re  input  1  read enable; captures ra.
- ore  input  1  output register enable; loads dout and dout_vld.
- dout  output  WIDTH  registered read data.
- dout_vld  output  1  dout holds data from a captured read.
- wa  input  AW  write address.
- we  input  1  write enable.
- di  input  WIDTH  write data.
- pwrbus_ram_pd  input  32  power-down bus; no functional effect, kept for interface compatibility.
- init_busy  output  1  high while the zero-init sweep runs.
- parity_err  output  1  parity mismatch on the last loaded word; 0 when the feature is compiled out.

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Reset values: state=INIT, init_addr=0, ra_d=0, rd_pend=0, dout=0, dout_vld=0, parity_err=0, init_busy=1.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes 0 (parity 0) to M[init_addr] and increments init_addr.
  - On the cycle it writes init_addr==DEPTH-1, the next state is RUN.
  - The sweep takes exactly DEPTH cycles. init_busy falls on the edge that enters RUN.
  - re, we and ore are ignored; dout, dout_vld and parity_err hold their reset values.
  - rst during INIT restarts the sweep at address 0.
- RUN write: if we, M[wa] <= di at the clock edge.
- RUN read stage 1: if re, ra_d <= ra and rd_pend <= 1. Else if ore, rd_pend <= 0. Otherwise ra_d and rd_pend hold.
- RUN read stage 2: if ore:
  - dout <= rdata, where rdata = (BYPASS && we && wa==ra_d) ? di : M[ra_d].
  - dout_vld <= rd_pend.
- If ore is low, dout and dout_vld hold.
- Latency: re at edge N, ore at edge N+1, data valid on dout after edge N+1. This is 2 cycles from address presentation, matching the legacy wrappers.
- Collision cases:
  - Write to ra in the same cycle as re: stage 2 reads the array after the write, so it always returns the new data regardless of BYPASS.
  - Write to ra_d in the same cycle as ore: BYPASS selects new (di) or old (array) data.
- Holding re=0 with ore=1 repeatedly re-reads M[ra_d]. dout_vld drops after the first such load unless re is reasserted.
- rst in RUN: array contents are re-zeroed by a fresh INIT sweep; any in-flight read is discarded (dout_vld=0).
- Out-of-range addresses (DEPTH not a power of two, address >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with dout_vld per the normal rules.

Optional Feature:
- Macro: NV_RAM_PARITY_EN.
- Defined:
  - The array stores WIDTH+1 bits; the extra bit is the even parity of di on write and 0 during INIT.
  - On every ore load, parity_err <= rd_pend && (^stored_word != 0).
  - The bypass path computes parity from di, so it never flags an error.
  - parity_err is not sticky; it updates on each ore load.
- Undefined: the array is WIDTH bits; parity_err is constant 0.

Test Plan:
- Reset then idle, DEPTH=128 -> init_busy high for exactly 128 cycles. Then read every address -> dout=0, dout_vld=1, parity_err=0.
- Write wa=5, di=0x2A5. Next cycle re with ra=5, then ore -> dout=0x2A5, dout_vld=1 two cycles after ra is presented.
- Preload M[9]=0x111. re with ra=9; next cycle ore with we, wa=9, di=0x7FF -> BYPASS=1 gives dout=0x7FF; BYPASS=0 gives dout=0x111.
- re/we asserted during INIT (cycle 40, wa=3, di=0x155) -> after init, a read of address 3 returns 0. Asserting rst at sweep cycle 60 -> init_busy stays high 128 further cycles.
- re once at ra=2, then ore on three consecutive cycles -> dout_vld sequence 1,0,0; dout stays M[2].
- With NV_RAM_PARITY_EN: write M[4]=0x003, force-flip the stored parity bit, read address 4 -> parity_err=1. Next read of a clean address -> parity_err=0.
